// File: rtl/vending_pkg.sv
// vending_pkg: encodings shared by the vending machine and the change dispenser
package vending_pkg;
  localparam int RS5_UNIT = 5;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_SELECT = 3'd1, S_REQ10 = 3'd2, S_REQ5 = 3'd3,
    S_GAP = 3'd4, S_DONE = 3'd5, S_FAULT = 3'd6
  } disp_state_t;
  localparam logic [2:0] RS5_COIN = 3'b001;
  localparam logic [2:0] RS10_COIN = 3'b010;
  localparam logic [2:0] RS5_RS10_COIN = 3'b011;
  localparam logic [2:0] RS10_RS10_COIN = 3'b100;
  localparam logic [2:0] RS25_COIN = 3'b101;
  typedef enum logic [2:0] {
    VM_IDLE, VM_FIVE, VM_TEN, VM_FIFTEEN, VM_TWENTY, VM_TWENTYFIVE
  } vm_state_t;
endpackage

// File: rtl/dispense_timer.sv
// dispense_timer: counts cycles a hopper request waits; expired on its last allowed cycle
module dispense_timer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] count;
  always_ff @(posedge clock or negedge reset)
    if (!reset) count <= '0;
    else count <= clear ? '0 : (enable && !expired) ? count + 1'b1 : count;
  // the edge that sees expired is the one where the count would reach TIMEOUT_CYCLES
  assign expired = count == TW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out change through Rs10/Rs5 hoppers, one coin per req/ack
module change_dispenser
  import vending_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             vend,
  input  logic [CNT_W-1:0] change,
  input  logic             clear_fault,
  input  logic             hop10_empty,
  input  logic             hop10_ack,
  input  logic             hop5_empty,
  input  logic             hop5_ack,
  output logic             ready,
  output logic             hop10_req,
  output logic             hop5_req,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] remaining,
  output logic [2:0]       state
);
  disp_state_t st, st_n;
  logic [CNT_W-1:0] rem_n;
  logic in_req, expired;
  assign in_req = st == S_REQ10 || st == S_REQ5;
  assign state = st;
  dispense_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock(clock), .reset(reset), .clear(!in_req), .enable(in_req), .expired(expired)
  );
  always_comb begin
    st_n = st;
    rem_n = remaining;
    case (st)
      S_IDLE: if (vend && change != '0) begin
        st_n = S_SELECT;
        rem_n = change;
      end
      S_SELECT: st_n = remaining == '0 ? S_DONE
                     : (remaining >= CNT_W'(2) && !hop10_empty) ? S_REQ10
                     : !hop5_empty ? S_REQ5 : S_FAULT;
      S_REQ10: if (hop10_ack) begin
        st_n = S_GAP;
        rem_n = remaining - CNT_W'(2);
      end else if (expired) st_n = S_FAULT;
      S_REQ5: if (hop5_ack) begin
        st_n = S_GAP;
        rem_n = remaining - CNT_W'(1);
      end else if (expired) st_n = S_FAULT;
      S_GAP: st_n = S_SELECT;
      S_DONE: st_n = S_IDLE;
      S_FAULT: if (clear_fault) begin
        st_n = S_IDLE;
        rem_n = '0;
      end
      default: st_n = S_IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with state
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      st <= S_IDLE;
      remaining <= '0;
      ready <= 1'b1;
      hop10_req <= 1'b0;
      hop5_req <= 1'b0;
      done <= 1'b0;
      fault <= 1'b0;
    end else begin
      st <= st_n;
      remaining <= rem_n;
      ready <= st_n == S_IDLE;
      hop10_req <= st_n == S_REQ10;
      hop5_req <= st_n == S_REQ5;
      done <= st_n == S_DONE;
      fault <= st_n == S_FAULT;
    end
endmodule
